// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: N-to-log2(N) one-hot / priority encoder with a registered
// valid/ready output stage and invalid-input flagging.
// Optional feature macro: ONEHOT_ENC_ERR_CNT_EN enables the saturating err_count
// counter; without it err_count is tied to zero and err_clr is ignored.
module onehot_encoder_pipe #(
    parameter int unsigned N             = 8,
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned CNT_W         = 8,
    localparam int unsigned W            = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    logic         found;
    logic         multi;
    logic [W-1:0] first_idx;
    logic [W-1:0] enc_idx;
    logic         enc_err;
    logic         accept;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_err_q, out_err_d;

    // Scan for the lowest set bit and note whether more than one bit is set
    always_comb begin
        found     = 1'b0;
        multi     = 1'b0;
        first_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_vec[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found     = 1'b1;
                    first_idx = W'(i);
                end
            end
        end
        // Multi-hot is only an error in strict mode; zero-hot is always an error
        enc_err = !found || ((PRIORITY_MODE == 0) && multi);
        enc_idx = enc_err ? '0 : first_idx;
    end

    // Output stage handshake: accept when empty or when the held result drains
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_idx_d = enc_idx;
            out_err_d = enc_err;
        end
    end

    // Output stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;

`ifdef ONEHOT_ENC_ERR_CNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Saturating count of accepted error beats; clear has priority
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (accept && enc_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench: a strict-mode (CNT_W=2) and a priority-mode instance share
// stimulus; expected results are queued at accept and compared at output.
module tb_onehot_encoder_pipe;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 3;
    localparam int unsigned C0 = 2;
    localparam int unsigned C1 = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  in_vec;
    logic          out_ready;
    logic          err_clr;

    logic          rdy0, rdy1, ov0, ov1, err0, err1;
    logic [W-1:0]  idx0, idx1;
    logic [C0-1:0] cnt0;
    logic [C1-1:0] cnt1;

    int total = 0;
    int bad   = 0;

    logic [W:0] q0[$];
    logic [W:0] q1[$];
    bit         exp_valid = 1'b0;
    int         exp_cnt0  = 0;
    int         exp_cnt1  = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.N(N), .PRIORITY_MODE(0), .CNT_W(C0)) u_strict (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_vec(in_vec),
        .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0), .out_err(err0),
        .err_clr(err_clr), .err_count(cnt0)
    );

    onehot_encoder_pipe #(.N(N), .PRIORITY_MODE(1), .CNT_W(C1)) u_prio (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_vec(in_vec),
        .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1), .out_err(err1),
        .err_clr(err_clr), .err_count(cnt1)
    );

    // Reference encoding: {err, idx}, built from popcount and isolated lowest bit
    function automatic logic [W:0] model(input logic [N-1:0] v, input bit prio);
        logic [N-1:0] low;
        logic [W-1:0] k;
        low = v & (~v + N'(1));
        k   = '0;
        if (v == '0) return {1'b1, W'(0)};
        if (!prio && ($countones(v) != 1)) return {1'b1, W'(0)};
        for (int b = 0; b < N; b++) if (low[b]) k = W'(b);
        return {1'b0, k};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs at negedge, advance the model, return at posedge+1
    task automatic step();
        logic [W:0] e;
        bit         acc;
        @(negedge clk);
        chk("out_valid0", 32'(ov0), 32'(exp_valid));
        chk("out_valid1", 32'(ov1), 32'(exp_valid));
        chk("in_ready0", 32'(rdy0), 32'(!exp_valid || out_ready));
        chk("in_ready1", 32'(rdy1), 32'(!exp_valid || out_ready));
        if (exp_valid && q0.size() > 0 && q1.size() > 0) begin
            e = q0[0];
            chk("idx0", 32'(idx0), 32'(e[W-1:0]));
            chk("err0", 32'(err0), 32'(e[W]));
            e = q1[0];
            chk("idx1", 32'(idx1), 32'(e[W-1:0]));
            chk("err1", 32'(err1), 32'(e[W]));
        end
        chk("cnt0", 32'(cnt0), 32'(exp_cnt0));
        chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
        if (!rst) begin
            acc = in_valid && (!exp_valid || out_ready);
            if (exp_valid && out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                q0.push_back(model(in_vec, 1'b0));
                q1.push_back(model(in_vec, 1'b1));
            end
`ifdef ONEHOT_ENC_ERR_CNT_EN
            if (err_clr) begin
                exp_cnt0 = 0;
                exp_cnt1 = 0;
            end else if (acc) begin
                e = model(in_vec, 1'b0);
                if (e[W] && exp_cnt0 < (1 << C0) - 1) exp_cnt0++;
                e = model(in_vec, 1'b1);
                if (e[W] && exp_cnt1 < (1 << C1) - 1) exp_cnt1++;
            end
`endif
            exp_valid = acc || (exp_valid && !out_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [N-1:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #1;
        chk("rst_valid", 32'(ov0), 32'd0);
        chk("rst_idx", 32'(idx0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic one-hot, multi-hot and zero-hot beats
        beat(8'b0010_0000);
        idle();
        beat(8'b0000_0110);
        idle();
        beat(8'b0000_0000);
        idle();
        beat(8'b1111_0000);
        beat(8'b1000_0000);
        idle();

        // Backpressure: hold one result, stall a second, then stream four
        out_ready = 1'b0;
        beat(8'h01);
        beat(8'h80);
        beat(8'h80);
        beat(8'h80);
        out_ready = 1'b1;
        beat(8'h80);
        beat(8'h04);
        beat(8'h08);
        beat(8'h10);
        idle();
        idle();

        // Error counter saturation, then clear colliding with an error beat
        repeat (5) beat(8'h00);
        idle();
        err_clr = 1'b1;
        beat(8'h00);
        err_clr = 1'b0;
        idle();
        beat(8'h03);
        idle();

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        beat(8'h41);
        idle();
        rst = 1'b1;
        #2;
        chk("arst_valid0", 32'(ov0), 32'd0);
        chk("arst_idx0", 32'(idx0), 32'd0);
        chk("arst_err0", 32'(err0), 32'd0);
        chk("arst_cnt0", 32'(cnt0), 32'd0);
        chk("arst_valid1", 32'(ov1), 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
        exp_valid = 1'b0;
        exp_cnt0  = 0;
        exp_cnt1  = 0;
        q0.delete();
        q1.delete();
        in_valid = 1'b0;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        beat(8'h08);
        idle();

        // Random beats with random backpressure
        for (int i = 0; i < 40; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0: in_vec = N'(1) << $urandom_range(0, N - 1);
                1: in_vec = '0;
                default: in_vec = N'($urandom);
            endcase
            step();
        end
        err_clr   = 1'b0;
        out_ready = 1'b1;
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
